// File: rtl/cam_ctrl_pkg.sv
// Shared state encoding and default widths for the camera capture sequencer.
package cam_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cam_state_t;

  localparam int FPS_WIDTH_DEF  = 32;
  localparam int DROP_WIDTH_DEF = 16;

endpackage

// File: rtl/cam_capture_sequencer_if.sv
// Camera-side control/status bundle between the register block, pixel pipeline and the sequencer.
interface cam_capture_sequencer_if
  import cam_ctrl_pkg::*;
#(
  parameter int FPS_WIDTH  = FPS_WIDTH_DEF,
  parameter int DROP_WIDTH = DROP_WIDTH_DEF
) ();

  logic                  trigger_capture_frame;
  logic                  continuous_capture_frame;
  logic                  dma_init_done;
  logic                  frame_start;
  logic                  frame_end;
  logic                  pixel_valid;
  logic                  capture_en;
  logic                  dma_start;
  logic                  busy;
  logic [FPS_WIDTH-1:0]  frames_captured;
  logic [FPS_WIDTH-1:0]  frames_per_second;
  logic [DROP_WIDTH-1:0] dropped_frames;

  modport master (
    output trigger_capture_frame, continuous_capture_frame, dma_init_done,
           frame_start, frame_end, pixel_valid,
    input  capture_en, dma_start, busy, frames_captured, frames_per_second, dropped_frames
  );

  modport slave (
    input  trigger_capture_frame, continuous_capture_frame, dma_init_done,
           frame_start, frame_end, pixel_valid,
    output capture_en, dma_start, busy, frames_captured, frames_per_second, dropped_frames
  );

endinterface

// File: rtl/cam_fps_meter.sv
// Free-running 1 s window; latches the number of completed frames seen in each full window.
module cam_fps_meter #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int FPS_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_done,
  output logic [FPS_WIDTH-1:0] frames_per_second
);

  localparam int            CW   = (CLK_FREQ_HZ > 2) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_FREQ_HZ - 1);

  logic [CW-1:0]        win_tick;
  logic [FPS_WIDTH-1:0] win_cnt;
  logic [FPS_WIDTH-1:0] win_next;

  // A frame finishing on the terminal cycle still belongs to the closing window.
  assign win_next = win_cnt + FPS_WIDTH'(frame_done);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_tick          <= '0;
      win_cnt           <= '0;
      frames_per_second <= '0;
    end else if (win_tick == LAST) begin
      win_tick          <= '0;
      win_cnt           <= '0;
      frames_per_second <= win_next;
    end else begin
      win_tick <= win_tick + CW'(1);
      win_cnt  <= win_next;
    end
  end

endmodule

// File: rtl/cam_capture_sequencer.sv
// Turns trigger/continuous capture requests into vsync-aligned capture windows and keeps
// capture/drop/fps statistics for one camera.
module cam_capture_sequencer
  import cam_ctrl_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int FPS_WIDTH   = FPS_WIDTH_DEF,
  parameter int DROP_WIDTH  = DROP_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  cam_capture_sequencer_if.slave  bus
);

  cam_state_t            state;
  logic                  trig_d;
  logic                  trig_pending;
  logic                  dma_start_q;
  logic                  busy_q;
  logic [FPS_WIDTH-1:0]  frames_captured_q;
  logic [DROP_WIDTH-1:0] dropped_q;

  logic trig_rise;
  logic go;
  logic consume;
  logic frame_done;
  logic drop_sat;

  assign trig_rise  = bus.trigger_capture_frame & ~trig_d;
  assign go         = (trig_pending | bus.continuous_capture_frame) & bus.dma_init_done;
  assign consume    = (state == ST_ARM) & go & bus.frame_start;
  // Abort has priority over a coincident frame_end.
  assign frame_done = (state == ST_CAPTURE) & bus.dma_init_done & bus.frame_end;
  assign drop_sat   = &dropped_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      trig_d            <= 1'b0;
      trig_pending      <= 1'b0;
      dma_start_q       <= 1'b0;
      busy_q            <= 1'b0;
      frames_captured_q <= '0;
      dropped_q         <= '0;
    end else begin
      trig_d      <= bus.trigger_capture_frame;
      dma_start_q <= 1'b0;
      // A rise landing on the consuming cycle queues for the following frame.
      if (consume)
        trig_pending <= trig_rise;
      else if (trig_rise)
        trig_pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (go) begin
            state  <= ST_ARM;
            busy_q <= 1'b1;
          end
        end
        ST_ARM: begin
          if (!go) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else if (bus.frame_start) begin
            state       <= ST_CAPTURE;
            dma_start_q <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (!bus.dma_init_done) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            if (!drop_sat) dropped_q <= dropped_q + DROP_WIDTH'(1);
          end else if (bus.frame_end) begin
            state             <= ST_DONE;
            frames_captured_q <= frames_captured_q + FPS_WIDTH'(1);
          end else if (bus.frame_start) begin
            dma_start_q <= 1'b1;
            if (!drop_sat) dropped_q <= dropped_q + DROP_WIDTH'(1);
          end
        end
        ST_DONE: begin
          if (go) begin
            state <= ST_ARM;
          end else begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.capture_en      = bus.pixel_valid & (state == ST_CAPTURE);
  assign bus.dma_start       = dma_start_q;
  assign bus.busy            = busy_q;
  assign bus.frames_captured = frames_captured_q;
  assign bus.dropped_frames  = dropped_q;

  cam_fps_meter #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .FPS_WIDTH   (FPS_WIDTH)
  ) u_fps (
    .clk               (clk),
    .reset             (reset),
    .frame_done        (frame_done),
    .frames_per_second (bus.frames_per_second)
  );

endmodule

// File: tb/tb_cam_capture_sequencer.sv
// Directed bench: each expected dma_start pulse is queued with the statistics it should carry.
module tb_cam_capture_sequencer;
  import cam_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_pass;

  typedef struct {
    int fc;
    int dr;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  cam_capture_sequencer_if #(.FPS_WIDTH(32), .DROP_WIDTH(16)) cif ();

  cam_capture_sequencer #(
    .CLK_FREQ_HZ (1000),
    .FPS_WIDTH   (32),
    .DROP_WIDTH  (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (cif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, want);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && cif.dma_start) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL dma_start_unexpected: got pulse at cycle %0d expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("dma_frames_captured", cif.frames_captured, mon_e.fc);
        check("dma_dropped", 32'(cif.dropped_frames), mon_e.dr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int fc, input int dr);
    exp_t e;
    e.fc = fc;
    e.dr = dr;
    sb.push_back(e);
  endtask

  task automatic pulse_fs();
    cif.frame_start = 1'b1;
    tick();
    cif.frame_start = 1'b0;
  endtask

  task automatic pulse_fe();
    cif.frame_end = 1'b1;
    tick();
    cif.frame_end = 1'b0;
  endtask

  task automatic rise();
    cif.trigger_capture_frame = 1'b0;
    tick();
    cif.trigger_capture_frame = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_busy", 32'(cif.busy), 0);
    check("rst_dma_start", 32'(cif.dma_start), 0);
    check("rst_frames_captured", cif.frames_captured, 0);
    check("rst_fps", cif.frames_per_second, 0);
    check("rst_dropped", 32'(cif.dropped_frames), 0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    cif.trigger_capture_frame    = 1'b0;
    cif.continuous_capture_frame = 1'b0;
    cif.dma_init_done            = 1'b1;
    cif.frame_start              = 1'b0;
    cif.frame_end                = 1'b0;
    cif.pixel_valid              = 1'b0;
    tick();

    // Single-shot trigger
    do_reset();
    rise();
    tick();
    check("ss_busy_arm", 32'(cif.busy), 1);
    cif.pixel_valid = 1'b1;
    #1;
    check("ss_capen_arm", 32'(cif.capture_en), 0);
    push(0, 0);
    pulse_fs();
    check("ss_capen_capture", 32'(cif.capture_en), 1);
    cif.pixel_valid = 1'b0;
    #1;
    check("ss_capen_nopix", 32'(cif.capture_en), 0);
    repeat (98) tick();
    pulse_fe();
    check("ss_frames_captured", cif.frames_captured, 1);
    tick();
    check("ss_busy_idle", 32'(cif.busy), 0);
    cif.pixel_valid = 1'b1;
    #1;
    check("ss_capen_idle", 32'(cif.capture_en), 0);
    cif.pixel_valid = 1'b0;
    cif.trigger_capture_frame = 1'b0;

    // Continuous, cleared during the fifth frame
    do_reset();
    cif.continuous_capture_frame = 1'b1;
    tick();
    for (int f = 0; f < 5; f++) begin
      push(f, 0);
      pulse_fs();
      repeat (5) tick();
      if (f == 4) cif.continuous_capture_frame = 1'b0;
      check("cont_busy_mid", 32'(cif.busy), 1);
      pulse_fe();
      check("cont_frames_captured", cif.frames_captured, f + 1);
      tick();
      check("cont_busy_after", 32'(cif.busy), (f == 4) ? 0 : 1);
    end

    // Abort, then abort coinciding with frame_end
    do_reset();
    rise();
    tick();
    push(0, 0);
    pulse_fs();
    repeat (3) tick();
    cif.dma_init_done = 1'b0;
    tick();
    check("abort_busy", 32'(cif.busy), 0);
    check("abort_dropped", 32'(cif.dropped_frames), 1);
    check("abort_frames_captured", cif.frames_captured, 0);
    pulse_fe();
    check("abort_fe_ignored", cif.frames_captured, 0);
    cif.dma_init_done = 1'b1;
    tick();
    check("abort_stays_idle", 32'(cif.busy), 0);
    rise();
    tick();
    check("abort2_busy_arm", 32'(cif.busy), 1);
    push(0, 1);
    pulse_fs();
    repeat (2) tick();
    cif.dma_init_done = 1'b0;
    cif.frame_end     = 1'b1;
    tick();
    cif.frame_end     = 1'b0;
    check("abort_fe_same_dropped", 32'(cif.dropped_frames), 2);
    check("abort_fe_same_captured", cif.frames_captured, 0);
    check("abort_fe_same_busy", 32'(cif.busy), 0);
    cif.dma_init_done = 1'b1;
    cif.trigger_capture_frame = 1'b0;

    // Truncated frame
    do_reset();
    rise();
    tick();
    push(0, 0);
    pulse_fs();
    repeat (3) tick();
    push(0, 1);
    pulse_fs();
    cif.pixel_valid = 1'b1;
    #1;
    check("trunc_dropped", 32'(cif.dropped_frames), 1);
    check("trunc_busy", 32'(cif.busy), 1);
    check("trunc_capen", 32'(cif.capture_en), 1);
    cif.pixel_valid = 1'b0;
    pulse_fe();
    check("trunc_frames_captured", cif.frames_captured, 1);
    cif.trigger_capture_frame = 1'b0;

    // Triggers queued during capture, then reset mid-capture
    do_reset();
    rise();
    tick();
    push(0, 0);
    pulse_fs();
    repeat (2) tick();
    rise();
    rise();
    rise();
    pulse_fe();
    tick();
    check("queue_rearm", 32'(cif.busy), 1);
    push(1, 0);
    pulse_fs();
    repeat (3) tick();
    pulse_fe();
    tick();
    check("queue_idle", 32'(cif.busy), 0);
    check("queue_frames_captured", cif.frames_captured, 2);
    repeat (5) tick();
    check("queue_no_extra", 32'(cif.busy), 0);
    rise();
    tick();
    push(2, 0);
    pulse_fs();
    repeat (2) tick();
    cif.pixel_valid = 1'b1;
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(cif.busy), 0);
    check("midrst_capen", 32'(cif.capture_en), 0);
    check("midrst_dma_start", 32'(cif.dma_start), 0);
    check("midrst_frames_captured", cif.frames_captured, 0);
    cif.pixel_valid = 1'b0;
    cif.trigger_capture_frame = 1'b0;
    tick();

    // FPS windows: 7 frames, then 7 more plus one ending on the terminal cycle
    cif.continuous_capture_frame = 1'b1;
    do_reset();
    tick();
    for (int f = 0; f < 7; f++) begin
      push(f, 0);
      pulse_fs();
      repeat (3) tick();
      pulse_fe();
      tick();
    end
    check("fps_pre_window", cif.frames_per_second, 0);
    while (cyc < 1000) tick();
    check("fps_window1", cif.frames_per_second, 7);
    for (int f = 0; f < 7; f++) begin
      push(7 + f, 0);
      pulse_fs();
      repeat (3) tick();
      pulse_fe();
      tick();
    end
    push(14, 0);
    pulse_fs();
    while (cyc < 1999) tick();
    check("fps_window1_hold", cif.frames_per_second, 7);
    pulse_fe();
    check("fps_window2_terminal", cif.frames_per_second, 8);
    check("fps_frames_captured", cif.frames_captured, 15);
    cif.continuous_capture_frame = 1'b0;
    repeat (3) tick();

    while (sb.size() > 0) begin
      void'(sb.pop_front());
      n_checks++;
      $display("FAIL dma_start_missing: got no pulse expected pulse");
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
